mem_arbiter: RTL and testbench

- Two-port request/acknowledge arbiter that shares the single-port 256x16 data RAM between requester 0 (CPU load/store unit) and requester 1 (program loader / debug port).
- Latches one request per transaction and drives the RAM's we/address/data_in for exactly one cycle.
- Captures the RAM's combinational read data and returns it with a one-cycle ack pulse.
- Sits between the CPU core and the RAM instance at top level.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state type for the two-port RAM arbiter.
// Holds the default address/data widths, the implemented RAM depth and the
// arbiter FSM state encoding.
package mem_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select between the two requesters.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: when defined, a last-grant
// pointer input decides conflicts in favour of the port not granted most
// recently; when undefined, port 0 always wins and the pointer input is absent.
module arb_pick (
    input  logic req0,
    input  logic req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_valid,
    output logic grant_idx
);

    // Decide whether anyone is requesting and which port wins
    always_comb begin
        grant_valid = req0 | req1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = 1'b1;
        end else begin
            grant_idx = 1'b0;
        end
`else
        if (req0) begin
            grant_idx = 1'b0;
        end else if (req1) begin
            grant_idx = 1'b1;
        end else begin
            grant_idx = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port request/acknowledge arbiter in front of a single-port RAM.
// One transaction at a time: latch in IDLE, drive the RAM for one cycle in
// ACCESS, pulse the owner's ack in RESP. All outputs are registered, so
// there is no combinational path from the request inputs to the RAM or acks.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed port-0 priority.
module mem_arbiter #(
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    import mem_pkg::*;

    // One extra bit keeps the compare correct even when MEM_DEPTH == 2**ADDR_W
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;

    logic              owner_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              in_range_r;

    logic              grant_valid_s;
    logic              grant_idx_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic              win_in_range_s;

    logic              ack0_r;
    logic              ack1_r;
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              mem_we_r;

    logic              ack0_nxt_s;
    logic              ack1_nxt_s;
    logic              mem_we_nxt_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_grant_r;
`endif

    arb_pick u_arb_pick (
        .req0        (req0),
        .req1        (req1),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant_r),
`endif
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Route the winning requester's fields toward the latch registers
    always_comb begin
        if (grant_idx_s) begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
        win_in_range_s = ({1'b0, win_addr_s} < DEPTH_LIM);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS:  state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: values the registered outputs take in the next cycle
    always_comb begin
        mem_we_nxt_s = 1'b0;
        ack0_nxt_s   = 1'b0;
        ack1_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    mem_we_nxt_s = win_we_s & win_in_range_s;
                end else begin
                    mem_we_nxt_s = 1'b0;
                end
            end
            ACCESS: begin
                ack0_nxt_s = ~owner_r;
                ack1_nxt_s = owner_r;
            end
            RESP: begin
                mem_we_nxt_s = 1'b0;
            end
            default: begin
                mem_we_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered strobes: write enable is high only during ACCESS, ack only during RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_r <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
        end else begin
            mem_we_r <= mem_we_nxt_s;
            ack0_r   <= ack0_nxt_s;
            ack1_r   <= ack1_nxt_s;
        end
    end

    // Latch the winning request; held steady until the next grant so the RAM pins never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r    <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            in_range_r <= 1'b0;
        end else if ((state_r == IDLE) && grant_valid_s) begin
            owner_r    <= grant_idx_s;
            we_r       <= win_we_s;
            addr_r     <= win_addr_s;
            wdata_r    <= win_wdata_s;
            in_range_r <= win_in_range_s;
        end else begin
            owner_r    <= owner_r;
            we_r       <= we_r;
            addr_r     <= addr_r;
            wdata_r    <= wdata_r;
            in_range_r <= in_range_r;
        end
    end

    // Capture RAM read data and the range flag at the edge closing ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else if (state_r == ACCESS) begin
            rdata_r <= (!we_r && in_range_r) ? mem_data_out : {DATA_W{1'b0}};
            err_r   <= ~in_range_r;
        end else begin
            rdata_r <= rdata_r;
            err_r   <= err_r;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remember the most recent grant; reset value 1 lets port 0 win the first conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if ((state_r == IDLE) && grant_valid_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign ack0        = ack0_r;
    assign ack1        = ack1_r;
    assign rdata       = rdata_r;
    assign err         = err_r;
    assign mem_we      = mem_we_r;
    assign mem_address = addr_r;
    assign mem_data_in = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized phase checked against a
// transaction-level model of the RAM contents and the arbitration rules.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = 16'h0, wdata0 = 16'h0, addr1 = 16'h0, wdata1 = 16'h0;
    logic        ack0, ack1, err, mem_we;
    logic [15:0] rdata, mem_address, mem_data_in, mem_data_out;

    int checks = 0;
    int passed = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err),
        .mem_we(mem_we), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 7) ^ 16'hA5A5;
    endfunction

    // 256x16 RAM model: decodes only the low 8 address bits, combinational read
    logic [15:0] ram [0:255];
    logic        ram_ready = 1'b0;
    assign mem_data_out = ram[mem_address[7:0]];
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_address[7:0]] <= mem_data_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_port(input logic p, input logic r, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One complete transaction on port p, started and checked at negedges
    task automatic do_txn(input string tag, input logic p, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err);
        int nwe;
        nwe = 0;
        set_port(p, 1'b1, w, a, d);
        tick();
        chk({tag, "_lat"}, {ack1, ack0}, 2'b00);
        if (mem_we) nwe++;
        tick();
        if (mem_we) nwe++;
        chk({tag, "_ack"}, {ack1, ack0}, p ? 2'b10 : 2'b01);
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_we_cnt"}, nwe, (w && !exp_err) ? 1 : 0);
        set_port(p, 1'b0, w, a, d);
        tick();
        chk({tag, "_ack_end"}, {ack1, ack0}, 2'b00);
    endtask

    typedef struct {
        string       tag;
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    // Random-phase state
    localparam int NCYC = 500;
    logic [15:0] ref_mem [0:255];
    logic [1:0]  hist [0:1023];
    logic        act [2];
    logic        just [2];
    logic        rwe [2];
    logic [15:0] raddr [2];
    logic [15:0] rwdata [2];
    int          wait_c [2];

    initial begin
        int          seq [$];
        int          ecnt, last_p, nwe_obs, nwe_exp;
        logic        prev_we, ackp, inr;
        logic [1:0]  lat;
        logic [15:0] exp_rd;

        vecs[0] = '{"v0_wr5",    1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000,     1'b0};
        vecs[1] = '{"v1_rd5",    1'b0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF,     1'b0};
        vecs[2] = '{"v2_wr100",  1'b0, 1'b1, 16'h0100, 16'h1234, 16'h0000,     1'b1};
        vecs[3] = '{"v3_rd0",    1'b0, 1'b0, 16'h0000, 16'h0000, init_val(0),  1'b0};
        vecs[4] = '{"v4_wrff",   1'b1, 1'b1, 16'h00FF, 16'hCAFE, 16'h0000,     1'b0};
        vecs[5] = '{"v5_rdff",   1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hCAFE,     1'b0};
        vecs[6] = '{"v6_rdffff", 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000,     1'b1};
        vecs[7] = '{"v7_rd100",  1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000,     1'b1};

        // Reset state
        tick(); tick();
        chk("rst_ack", {ack1, ack0}, 2'b00);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_address, 16'h0000);
        chk("rst_mem_din", mem_data_in, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].tag, vecs[i].port, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);

        // Simultaneous read requests: port 0 first, port 1 three cycles later
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0007, 16'h0);
        tick();
        chk("sim_c1", {ack1, ack0}, 2'b00);
        tick();
        chk("sim_ack0", {ack1, ack0}, 2'b01);
        chk("sim_rd0", rdata, init_val(3));
        req0 = 1'b0;
        tick();
        chk("sim_c3", {ack1, ack0}, 2'b00);
        tick();
        chk("sim_c4", {ack1, ack0}, 2'b00);
        tick();
        chk("sim_ack1", {ack1, ack0}, 2'b10);
        chk("sim_rd1", rdata, init_val(7));
        req1 = 1'b0;
        tick();

        // Both requesters held high for six transactions
        do_reset();
        set_port(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0);
        set_port(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0);
        for (int c = 0; c < 40 && seq.size() < 6; c++) begin
            tick();
            if (ack0) begin seq.push_back(0); chk("hold_rd0", rdata, init_val(1)); end
            if (ack1) begin seq.push_back(1); chk("hold_rd1", rdata, init_val(2)); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("hold_count", seq.size(), 6);
        for (int i = 0; i < seq.size() && i < 6; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("hold_order", seq[i], i % 2);
`else
            chk("hold_order", seq[i], 0);
`endif
        end
        tick(); tick(); tick();

        // Reset during ACCESS of a write suppresses the write and the ack
        set_port(1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA);
        tick();
        chk("rmid_we_pre", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rmid_we_now", mem_we, 1'b0);
        chk("rmid_addr", mem_address, 16'h0000);
        req0 = 1'b0;
        tick();
        chk("rmid_ack_a", {ack1, ack0}, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("rmid_ack_b", {ack1, ack0}, 2'b00);
        chk("rmid_ram", ram[8'h10], init_val(16));
        do_txn("rmid_rd", 1'b0, 1'b0, 16'h0010, 16'h0, init_val(16), 1'b0);

        // Requester inputs changing after the latch edge are ignored
        set_port(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
        tick();
        set_port(1'b0, 1'b1, 1'b1, 16'h0021, 16'h6666);
        #1;
        chk("chg_addr", mem_address, 16'h0020);
        chk("chg_din", mem_data_in, 16'h5555);
        chk("chg_we", mem_we, 1'b1);
        tick();
        chk("chg_ack", {ack1, ack0}, 2'b01);
        req0 = 1'b0;
        tick();
        do_txn("chg_rd20", 1'b0, 1'b0, 16'h0020, 16'h0, 16'h5555, 1'b0);
        do_txn("chg_rd21", 1'b0, 1'b0, 16'h0021, 16'h0, init_val(33), 1'b0);

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        for (int p = 0; p < 2; p++) begin act[p] = 1'b0; just[p] = 1'b0; wait_c[p] = 0; end
        ecnt = 0; last_p = 1; nwe_obs = 0; nwe_exp = 0; prev_we = 1'b0;
        hist[1] = 2'b00;
        for (int c = 0; c < NCYC + 60; c++) begin
            tick();
            ecnt++;
            if (mem_we) begin
                nwe_obs++;
                if (prev_we) chk("rnd_we_pulse", mem_we, 1'b0);
            end
            prev_we = mem_we;
            if (ack0 && ack1) chk("rnd_both_ack", {ack1, ack0}, 2'b01);
            for (int p = 0; p < 2; p++) begin
                ackp = (p == 1) ? ack1 : ack0;
                if (ackp) begin
                    if (!act[p]) begin
                        chk("rnd_spurious", act[p], 1'b1);
                    end else begin
                        lat = hist[ecnt-1];
                        chk("rnd_req_at_grant", lat[p], 1'b1);
                        if (lat == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            chk("rnd_rr_winner", p, 1 - last_p);
`else
                            chk("rnd_fixed_winner", p, 0);
`endif
                        end
                        inr = (raddr[p] < 16'd256);
                        exp_rd = (rwe[p] || !inr) ? 16'h0000 : ref_mem[raddr[p][7:0]];
                        chk("rnd_rdata", rdata, exp_rd);
                        chk("rnd_err", err, !inr);
                        if (rwe[p] && inr) begin
                            ref_mem[raddr[p][7:0]] = rwdata[p];
                            nwe_exp++;
                        end
                        last_p = p;
                        act[p] = 1'b0;
                        just[p] = 1'b1;
                        set_port(p[0], 1'b0, rwe[p], raddr[p], rwdata[p]);
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (act[p]) begin
                    wait_c[p]++;
                    if (wait_c[p] > 40) begin
                        chk("rnd_timeout", wait_c[p], 40);
                        act[p] = 1'b0;
                        set_port(p[0], 1'b0, rwe[p], raddr[p], rwdata[p]);
                    end
                end else if (!just[p] && c < NCYC && ($urandom % 3) == 0) begin
                    rwe[p] = $urandom % 2 == 1;
                    if ($urandom % 6 == 0) raddr[p] = 16'h0100 + 16'($urandom % 16'hFF00);
                    else                   raddr[p] = 16'h0040 + 16'($urandom % 16);
                    rwdata[p] = 16'($urandom);
                    wait_c[p] = 0;
                    act[p] = 1'b1;
                    set_port(p[0], 1'b1, rwe[p], raddr[p], rwdata[p]);
                end
                just[p] = 1'b0;
            end
            hist[ecnt+1] = {req1, req0};
        end
        chk("rnd_we_count", nwe_obs, nwe_exp);
        chk("rnd_drained", {act[1], act[0]}, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
